// File: rtl/camera_stream_rx.sv
// Camera pixel receiver: frame tracking (sof/eol tagging) into a show-ahead FIFO with a valid/ready output.
// Latency 2 edges from pixel capture to out_valid; overflow drops pixels until the next sof. Option: CAMERA_RX_FRAME_CHECK_EN adds frame_err.
module camera_stream_rx #(
    parameter int PIXEL_W    = 24,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PIXEL_W-1:0]            pixel_data,
    input  logic                          pixel_valid,
    input  logic                          cam_sof,
    input  logic                          clear_status,
    output logic [PIXEL_W-1:0]            out_data,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frame_count,
    output logic                          overflow,
    output logic                          busy
`ifdef CAMERA_RX_FRAME_CHECK_EN
    ,
    output logic                          frame_err
`endif
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = PIXEL_W + 2;
    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [PW:0]   LVL_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DROP} state_t;

    state_t          r_state, w_state_nxt;
    logic [XW-1:0]   r_x, w_x_nxt;
    logic [YW-1:0]   r_y, w_y_nxt;
    logic            w_full, w_wr_en, w_wr_sof, w_wr_eol, w_fc_inc, w_ovf_set, w_at_eol;
    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [PW:0]     r_wr_ptr, r_rd_ptr, w_mem_cnt, r_level;
    logic            w_load, w_pop;

    assign w_full   = (r_level == LVL_FULL);
    assign w_at_eol = (r_x == X_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_wr_en     = 1'b0;
        w_wr_sof    = 1'b0;
        w_fc_inc    = 1'b0;
        w_ovf_set   = 1'b0;
        // A full FIFO takes priority over everything, including an sof restart.
        if (pixel_valid && (cam_sof || r_state == ST_ACTIVE)) begin
            if (w_full) begin
                w_ovf_set   = 1'b1;
                w_state_nxt = ST_DROP;
            end else if (cam_sof) begin
                w_wr_en     = 1'b1;
                w_wr_sof    = 1'b1;
                w_x_nxt     = XW'(1);
                w_y_nxt     = '0;
                w_state_nxt = ST_ACTIVE;
            end else begin
                w_wr_en = 1'b1;
                if (w_at_eol) begin
                    w_x_nxt = '0;
                    if (r_y == Y_LAST) begin
                        w_y_nxt     = '0;
                        w_fc_inc    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_y_nxt = r_y + YW'(1);
                    end
                end else begin
                    w_x_nxt = r_x + XW'(1);
                end
            end
        end
    end

    assign w_wr_eol = w_at_eol && !w_wr_sof;
    assign busy     = (r_state != ST_IDLE);

    assign w_mem_cnt = r_wr_ptr - r_rd_ptr;
    assign w_pop     = out_valid && out_ready;
    assign w_load    = (w_mem_cnt != '0) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[PW-1:0]] <= {w_wr_sof, w_wr_eol, pixel_data};
    end

    // fifo_level counts the output register too, so capacity is exactly FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_data  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (PW + 1)'(1);
            if (w_load) begin
                {out_sof, out_eol, out_data} <= r_mem[r_rd_ptr[PW-1:0]];
                out_valid <= 1'b1;
                r_rd_ptr  <= r_rd_ptr + (PW + 1)'(1);
            end else if (w_pop) begin
                out_valid <= 1'b0;
            end
            r_level <= r_level + {{PW{1'b0}}, w_wr_en} - {{PW{1'b0}}, w_pop};
        end
    end
    assign fifo_level = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (w_fc_inc) frame_count <= frame_count + 16'd1;
            if (w_ovf_set)         overflow <= 1'b1;
            else if (clear_status) overflow <= 1'b0;
        end
    end

`ifdef CAMERA_RX_FRAME_CHECK_EN
    logic r_seen, w_ferr_set;
    assign w_ferr_set = (r_state == ST_ACTIVE && pixel_valid && cam_sof && !w_full) ||
                        (r_state == ST_IDLE && pixel_valid && !cam_sof && r_seen);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (w_fc_inc) r_seen <= 1'b1;
            if (w_ferr_set)        frame_err <= 1'b1;
            else if (clear_status) frame_err <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_camera_stream_rx.sv
// Randomised and directed bench for camera_stream_rx against a frame-index/queue reference model.
module tb_camera_stream_rx;
    localparam int H = 4, V = 2, DEPTH = 4;
`ifdef CAMERA_RX_FRAME_CHECK_EN
    localparam bit FERR_EN = 1'b1;
`else
    localparam bit FERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pixel_data = '0;
    logic        pixel_valid = 1'b0, cam_sof = 1'b0, clear_status = 1'b0, out_ready = 1'b0;
    logic [23:0] out_data;
    logic        out_sof, out_eol, out_valid, overflow, busy;
    logic [2:0]  fifo_level;
    logic [15:0] frame_count;
    logic        w_ferr;

    camera_stream_rx #(.PIXEL_W(24), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .cam_sof(cam_sof), .clear_status(clear_status), .out_data(out_data), .out_sof(out_sof),
        .out_eol(out_eol), .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
        .frame_count(frame_count), .overflow(overflow), .busy(busy)
`ifdef CAMERA_RX_FRAME_CHECK_EN
        , .frame_err(w_ferr)
`endif
    );
`ifndef CAMERA_RX_FRAME_CHECK_EN
    assign w_ferr = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [23:0] d;
        int          w;
    } ent_t;

    // Reference model: pixels buffered in a queue, frame position as a flat pixel index.
    ent_t        m_q[$];
    logic [25:0] obs[$];
    int          m_edge = 0, m_idx = 0, m_mode = 0;   // mode: 0 waiting, 1 in frame, 2 dropping
    logic [15:0] m_fc = '0;
    logic        m_ovf = 0, m_ferr = 0, m_seen = 0;
    int          errors = 0, checks = 0;

    logic [48:0] act_vec;
    assign act_vec = {out_valid, out_valid ? {out_sof, out_eol, out_data} : 26'd0,
                      fifo_level, frame_count, overflow, busy, w_ferr};

    function automatic logic [48:0] exp_vec();
        logic v;
        ent_t h;
        v = (m_q.size() > 0) && (m_q[0].w < m_edge);
        h = v ? m_q[0] : '0;
        return {v, h.sof, h.eol, h.d, 3'(m_q.size()), m_fc, m_ovf, (m_mode != 0), FERR_EN & m_ferr};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_idx = 0; m_mode = 0; m_fc = '0; m_ovf = 0; m_ferr = 0; m_seen = 0;
    endtask

    task automatic model_update();
        logic full;
        ent_t e;
        full = (m_q.size() == DEPTH);
        if (m_q.size() > 0 && m_q[0].w < m_edge && out_ready) void'(m_q.pop_front());
        m_edge++;
        if (clear_status) begin m_ovf = 0; m_ferr = 0; end
        if (pixel_valid) begin
            if (m_mode == 1 || cam_sof) begin
                if (full) begin
                    m_ovf = 1; m_mode = 2;
                end else if (cam_sof) begin
                    if (m_mode == 1) m_ferr = 1;
                    e.sof = 1; e.eol = 0; e.d = pixel_data; e.w = m_edge;
                    m_q.push_back(e);
                    m_idx = 1; m_mode = 1;
                end else begin
                    e.sof = 0; e.eol = ((m_idx % H) == H - 1); e.d = pixel_data; e.w = m_edge;
                    m_q.push_back(e);
                    m_idx++;
                    if (m_idx == H * V) begin m_fc++; m_seen = 1; m_mode = 0; end
                end
            end else if (m_mode == 0 && m_seen) begin
                m_ferr = 1;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic pv, input logic sof, input logic [23:0] d,
                        input logic rdy, input logic clr);
        pixel_valid = pv; cam_sof = sof; pixel_data = d; out_ready = rdy; clear_status = clr;
        if (out_valid && out_ready) obs.push_back({out_sof, out_eol, out_data});
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        pixel_valid = 0; cam_sof = 0; clear_status = 0; out_ready = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply_reset();
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_vec got=%h exp=%h", act_vec, exp_vec());
        end
        checks++;
        if (out_data !== 24'd0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin
            errors++; $display("FAIL reset_outregs got=%h/%b/%b exp=0", out_data, out_sof, out_eol);
        end
    endtask

    task automatic test_full_frame();
        apply_reset();
        obs.delete();
        for (int i = 0; i < 8; i++) begin
            step(1, i == 0, 24'(i + 1), 1, 0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL full_frame_vec[%0d] got=%h exp=%h", i, act_vec, exp_vec());
            end
        end
        checks++;
        if (frame_count !== 16'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL full_frame_status got fc=%0d busy=%b exp fc=1 busy=0", frame_count, busy);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 24'd0, 1, 0);
        checks++;
        if (obs.size() != 8) begin
            errors++; $display("FAIL full_frame_count got=%0d exp=8", obs.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs[i] !== {i == 0, i == 3 || i == 7, 24'(i + 1)}) begin
                    errors++; $display("FAIL full_frame_beat[%0d] got=%h exp=%h", i, obs[i],
                                       {i == 0, i == 3 || i == 7, 24'(i + 1)});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 4; i++) step(1, i == 0, 24'(i + 1), 0, 0);
        step(0, 0, 24'd0, 0, 0);
        checks++;
        if (fifo_level !== 3'd4 || out_data !== 24'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL backpressure_hold got lvl=%0d data=%h exp lvl=4 data=000001", fifo_level, out_data);
        end
        obs.delete();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 24'd0, 1, 0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL backpressure_vec[%0d] got=%h exp=%h", i, act_vec, exp_vec());
            end
        end
        checks++;
        if (obs.size() != 4 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL backpressure_drain got beats=%0d lvl=%0d exp 4/0", obs.size(), fifo_level);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, i == 0, 24'h11 + 24'(i), 0, 0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL overflow_vec[%0d] got=%h exp=%h", i, act_vec, exp_vec());
            end
            if (i == 4) begin
                checks++;
                if (overflow !== 1'b1 || busy !== 1'b1 || frame_count !== 16'd0) begin
                    errors++; $display("FAIL overflow_set got ovf=%b busy=%b fc=%0d exp 1/1/0", overflow, busy, frame_count);
                end
            end
        end
        for (int i = 0; i < 6; i++) step(0, 0, 24'd0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, i == 0, 24'h40 + 24'(i), 1, 0);
        checks++;
        if (frame_count !== 16'd1 || overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_recover got fc=%0d ovf=%b exp fc=1 ovf=1", frame_count, overflow);
        end
        step(0, 0, 24'd0, 1, 1);
        checks++;
        if (overflow !== 1'b0 || act_vec !== exp_vec()) begin
            errors++; $display("FAIL overflow_clear got ovf=%b vec=%h exp ovf=0 vec=%h", overflow, act_vec, exp_vec());
        end
    endtask

    task automatic test_restart();
        apply_reset();
        obs.delete();
        for (int i = 0; i < 10; i++) begin
            step(1, i == 0 || i == 2, 24'(i + 1), 1, 0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL restart_vec[%0d] got=%h exp=%h", i, act_vec, exp_vec());
            end
        end
        checks++;
        if (w_ferr !== FERR_EN || frame_count !== 16'd1) begin
            errors++; $display("FAIL restart_status got ferr=%b fc=%0d exp ferr=%b fc=1", w_ferr, frame_count, FERR_EN);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 24'd0, 1, 0);
        checks++;
        if (obs.size() != 10 || obs[2] !== {2'b10, 24'd3} || obs[5] !== {2'b01, 24'd6}) begin
            errors++; $display("FAIL restart_beats got n=%0d b2=%h b5=%h exp n=10 b2=2000003 b5=1000006",
                               obs.size(), obs[2], obs[5]);
        end
    endtask

    task automatic test_stray_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 24'hA0 + 24'(i), 1, 0);
            checks++;
            if (act_vec !== exp_vec() || out_valid !== 1'b0) begin
                errors++; $display("FAIL stray_vec[%0d] got=%h exp=%h", i, act_vec, exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) step(1, i == 0, 24'hB0 + 24'(i), 0, 0);
        checks++;
        if (fifo_level !== 3'd3) begin
            errors++; $display("FAIL stray_fill got lvl=%0d exp=3", fifo_level);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (fifo_level !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset got lvl=%0d valid=%b busy=%b exp 0/0/0", fifo_level, out_valid, busy);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 24'd0, 1, 0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL post_reset_vec[%0d] got=%h exp=%h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic pv, sof, rdy, clr;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            pv  = ($urandom_range(0, 3) != 0);
            sof = ($urandom_range(0, 15) == 0);
            rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 40) == 0);
            step(pv, sof, 24'($urandom), rdy, clr);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL random_vec[%0d] got=%h exp=%h", i, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_overflow();
        test_restart();
        test_stray_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
